// File: rtl/cam_readout_ctrl_if.sv
// Wishbone slave bus bundle for the camera readout controller.
// A cycle is requested while wb_stb_i & wb_cyc_i are high; it completes on the single-cycle wb_ack_o pulse.
interface cam_readout_ctrl_if;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport slave (
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/cam_readout_ctrl.sv
// Sequences one camera frame capture, then reads the nibble-wide capture RAM
// and packs 8 nibbles per 32-bit word for the CPU to pop through the DATA register.
module cam_readout_ctrl #(
   parameter int RAM_AW = 4
) (
   input  logic              clk,
   input  logic              reset,
   cam_readout_ctrl_if.slave wb,
   input  logic              cam_ready_i,
   output logic              cam_enable_o,
   output logic              cam_rd_o,
   output logic [RAM_AW-1:0] cam_addr_o,
   input  logic [3:0]        cam_data_i,
   output logic              irq_o,
   output logic [2:0]        dbg_state
);

   localparam int CW = RAM_AW - 2;
   localparam logic [CW-1:0] NW = CW'(1 << (RAM_AW - 3));

   typedef enum logic [2:0] {
      IDLE, WAIT_RDY, FETCH_A, FETCH_R, FETCH_S, HOLD, DONE
   } state_t;

   state_t            state;
   logic [1:0]        ready_s;
   logic              ready_q;
   logic              continuous;
   logic              irq_en;
   logic              frame_done;
   logic              underrun;
   logic              word_valid;
   logic [CW-1:0]     count;
   logic [2:0]        nib;
   logic [RAM_AW-1:0] addr;
   logic [31:0]       word;
   logic              enable;
   logic              rd;
   logic              ack;
   logic [31:0]       dat_o;
   logic [31:0]       rdata;

   logic       req, wr, rd_req, ctrl_wr, arm, abort, stat_wr, pop_req, pop, busy, rdy_rise;
   logic [1:0] sel;

   assign req      = wb.wb_stb_i & wb.wb_cyc_i & ~ack;
   assign sel      = wb.wb_adr_i[3:2];
   assign wr       = req & wb.wb_we_i;
   assign rd_req   = req & ~wb.wb_we_i;
   assign ctrl_wr  = wr & (sel == 2'd0);
   assign arm      = ctrl_wr & wb.wb_dat_i[0];
   assign abort    = ctrl_wr & wb.wb_dat_i[3];
   assign stat_wr  = wr & (sel == 2'd1);
   assign pop_req  = rd_req & (sel == 2'd2);
   assign pop      = pop_req & word_valid;
   assign busy     = (state != IDLE);
   // Edge, not level: a ready flag left high from a previous frame must not restart a fetch.
   assign rdy_rise = ready_s[1] & ~ready_q;

   logic unused_bits;
   assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:4]};

   always_comb begin
      rdata = '0;
      case (sel)
         2'd0: rdata[2:1] = {irq_en, continuous};
         2'd1: rdata[3:0] = {underrun, frame_done, word_valid, busy};
         2'd2: rdata      = word_valid ? word : 32'd0;
         default: rdata[CW-1:0] = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ready_s    <= '0;
         ready_q    <= 1'b0;
         continuous <= 1'b0;
         irq_en     <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         word_valid <= 1'b0;
         count      <= '0;
         nib        <= '0;
         addr       <= '0;
         word       <= '0;
         enable     <= 1'b0;
         rd         <= 1'b0;
         ack        <= 1'b0;
         dat_o      <= '0;
      end else begin
         ack     <= req;
         ready_s <= {ready_s[0], cam_ready_i};
         ready_q <= ready_s[1];
         if (req) dat_o <= wb.wb_we_i ? 32'd0 : rdata;

         if (ctrl_wr) begin
            continuous <= wb.wb_dat_i[1];
            irq_en     <= wb.wb_dat_i[2];
         end
         if (stat_wr) begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
         end
         if (pop_req && !word_valid) underrun <= 1'b1;

         if (abort) begin
            state      <= IDLE;
            enable     <= 1'b0;
            rd         <= 1'b0;
            word_valid <= 1'b0;
            count      <= '0;
         end else begin
            case (state)
               IDLE: if (arm) begin
                  state  <= WAIT_RDY;
                  enable <= 1'b1;
                  count  <= NW;
                  nib    <= '0;
                  addr   <= '0;
               end
               WAIT_RDY: if (rdy_rise) begin
                  state  <= FETCH_A;
                  enable <= 1'b0;
               end
               FETCH_A: begin
                  rd    <= 1'b1;
                  state <= FETCH_R;
               end
               FETCH_R: begin
                  rd    <= 1'b0;
                  state <= FETCH_S;
               end
               FETCH_S: begin
                  word[{nib, 2'b00} +: 4] <= cam_data_i;
                  addr <= addr + 1'b1;
                  if (nib == 3'd7) begin
                     word_valid <= 1'b1;
                     state      <= HOLD;
                  end else begin
                     nib   <= nib + 1'b1;
                     state <= FETCH_A;
                  end
               end
               HOLD: if (pop) begin
                  word_valid <= 1'b0;
                  count      <= count - 1'b1;
                  if (count == CW'(1)) begin
                     state <= DONE;
                  end else begin
                     nib   <= '0;
                     state <= FETCH_A;
                  end
               end
               DONE: begin
                  frame_done <= 1'b1;
                  nib        <= '0;
                  if (continuous) begin
                     state  <= WAIT_RDY;
                     enable <= 1'b1;
                     count  <= NW;
                     addr   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign wb.wb_ack_o  = ack;
   assign wb.wb_dat_o  = dat_o;
   assign cam_enable_o = enable;
   assign cam_rd_o     = rd;
   assign cam_addr_o   = addr;
   assign irq_o        = frame_done & irq_en;
   assign dbg_state    = state;

endmodule

// File: tb/tb_cam_readout_ctrl.sv
// Self-checking bench for cam_readout_ctrl: a behavioural RAM plus a word-packing
// reference model computed from the RAM contents, exercised by one task per scenario.
module tb_cam_readout_ctrl;
   localparam int RAM_AW = 4;
   localparam int NN     = 1 << RAM_AW;
   localparam int NW     = NN / 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cam_ready = 1'b0;
   logic              cam_enable;
   logic              cam_rd;
   logic [RAM_AW-1:0] cam_addr;
   logic [3:0]        cam_data = 4'd0;
   logic              irq;
   logic [2:0]        dbg_state;

   cam_readout_ctrl_if wb ();

   cam_readout_ctrl #(.RAM_AW(RAM_AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb           (wb),
      .cam_ready_i  (cam_ready),
      .cam_enable_o (cam_enable),
      .cam_rd_o     (cam_rd),
      .cam_addr_o   (cam_addr),
      .cam_data_i   (cam_data),
      .irq_o        (irq),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   // Capture RAM: registers the addressed nibble on the rising edge while rd is high.
   logic [3:0] ram [NN];
   always @(posedge clk) if (cam_rd) cam_data <= ram[cam_addr];

   int rd_pulses = 0;
   always @(posedge clk) if (cam_rd) rd_pulses <= rd_pulses + 1;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int total  = 0;
   int passed = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: word j holds nibbles 8j..8j+7, lowest address in the lowest nibble.
   function automatic void build_expected();
      logic [31:0] w;
      exp_q.delete();
      for (int j = 0; j < NW; j++) begin
         w = 32'd0;
         for (int i = 0; i < 8; i++) w = w + (32'(ram[j*8+i]) << (4*i));
         exp_q.push_back(w);
      end
   endfunction

   task automatic wb_xfer(input logic we, input logic [1:0] sel, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
      @(negedge clk);
      wb.wb_stb_i = 1'b1;
      wb.wb_cyc_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_adr_i = {28'd0, sel, 2'b00};
      wb.wb_dat_i = wdata;
      lat   = 0;
      rdata = 32'hDEAD_BEEF;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (wb.wb_ack_o) begin
            lat   = i;
            rdata = wb.wb_dat_o;
            break;
         end
      end
      wb.wb_stb_i = 1'b0;
      wb.wb_cyc_i = 1'b0;
      wb.wb_we_i  = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] sel, output logic [31:0] d);
      int lat;
      wb_xfer(1'b0, sel, 32'd0, d, lat);
   endtask

   task automatic wb_write(input logic [1:0] sel, input logic [31:0] d);
      logic [31:0] r;
      int lat;
      wb_xfer(1'b1, sel, d, r, lat);
   endtask

   task automatic pulse_ready();
      @(negedge clk) cam_ready = 1'b1;
      repeat (4) @(negedge clk);
      cam_ready = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      logic [31:0] s;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wb_read(2'd1, s);
         if (s[1]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_frame(output bit ok_all);
      bit ok;
      logic [31:0] d;
      ok_all = 1'b1;
      got_q.delete();
      for (int w = 0; w < NW; w++) begin
         wait_valid(ok);
         if (!ok) ok_all = 1'b0;
         wb_read(2'd2, d);
         got_q.push_back(d);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat;
      total++; if (cam_enable !== 1'b0) $display("FAIL reset_enable got=%b exp=0", cam_enable); else passed++;
      total++; if (cam_rd !== 1'b0) $display("FAIL reset_rd got=%b exp=0", cam_rd); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
      total++; if (cam_addr !== '0) $display("FAIL reset_addr got=%h exp=0", cam_addr); else passed++;
      wb_xfer(1'b0, 2'd1, 32'd0, d, lat);
      total++; if (lat !== 1) $display("FAIL reset_ack_latency got=%0d exp=1", lat); else passed++;
      total++; if (d !== 32'd0) $display("FAIL reset_status got=%h exp=0", d); else passed++;
      @(posedge clk); #1;
      total++; if (wb.wb_ack_o !== 1'b0) $display("FAIL ack_one_cycle got=%b exp=0", wb.wb_ack_o); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd0) $display("FAIL reset_count got=%h exp=0", d); else passed++;
      wb_read(2'd0, d);
      total++; if (d !== 32'd0) $display("FAIL reset_ctrl got=%h exp=0", d); else passed++;
   endtask

   task automatic test_single_frame();
      logic [31:0] d;
      bit ok;
      int lat, rd0;
      for (int i = 0; i < NN; i++) ram[i] = 4'(i);
      rd0 = rd_pulses;
      wb_write(2'd0, 32'h1);
      total++; if (cam_enable !== 1'b1) $display("FAIL arm_enable got=%b exp=1", cam_enable); else passed++;
      @(negedge clk) cam_ready = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (!cam_enable) begin
            lat = i;
            break;
         end
      end
      total++; if (lat !== 3) $display("FAIL enable_drop_latency got=%0d exp=3", lat); else passed++;
      @(negedge clk) cam_ready = 1'b0;
      wait_valid(ok);
      total++; if (ok !== 1'b1) $display("FAIL first_word_timeout got=%b exp=1", ok); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd2) $display("FAIL count_before_pop got=%h exp=2", d); else passed++;
      wb_read(2'd2, d);
      total++; if (d !== 32'h7654_3210) $display("FAIL data_word0 got=%h exp=76543210", d); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd1) $display("FAIL count_after_pop got=%h exp=1", d); else passed++;
      wait_valid(ok);
      total++; if (ok !== 1'b1) $display("FAIL second_word_timeout got=%b exp=1", ok); else passed++;
      wb_read(2'd2, d);
      total++; if (d !== 32'hFEDC_BA98) $display("FAIL data_word1 got=%h exp=fedcba98", d); else passed++;
      repeat (3) @(posedge clk);
      wb_read(2'd1, d);
      total++; if (d !== 32'h4) $display("FAIL frame_done_status got=%h exp=4", d); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd0) $display("FAIL count_frame_end got=%h exp=0", d); else passed++;
      total++; if (rd_pulses - rd0 !== NN) $display("FAIL rd_strobes got=%0d exp=%0d", rd_pulses - rd0, NN); else passed++;
      wb_write(2'd1, 32'd0);
      wb_read(2'd1, d);
      total++; if (d !== 32'd0) $display("FAIL status_clear got=%h exp=0", d); else passed++;
   endtask

   task automatic test_underrun();
      logic [31:0] d;
      wb_write(2'd0, 32'h1);
      pulse_ready();
      wb_read(2'd2, d);
      total++; if (d !== 32'd0) $display("FAIL underrun_data got=%h exp=0", d); else passed++;
      wb_read(2'd1, d);
      total++; if (d[3] !== 1'b1 || d[0] !== 1'b1) $display("FAIL underrun_flag got=%h exp=bits3,0 set", d); else passed++;
      wb_write(2'd0, 32'h8);
      total++; if (cam_enable !== 1'b0 || cam_rd !== 1'b0) $display("FAIL abort_pins got=%b%b exp=00", cam_enable, cam_rd); else passed++;
      wb_read(2'd1, d);
      total++; if (d !== 32'h8) $display("FAIL abort_keeps_sticky got=%h exp=8", d); else passed++;
      wb_write(2'd1, 32'd0);
      wb_read(2'd1, d);
      total++; if (d !== 32'd0) $display("FAIL underrun_clear got=%h exp=0", d); else passed++;
   endtask

   task automatic test_continuous();
      logic [31:0] d;
      bit ok;
      for (int i = 0; i < NN; i++) ram[i] = 4'(i);
      build_expected();
      wb_write(2'd0, 32'h7);
      for (int f = 0; f < 2; f++) begin
         pulse_ready();
         pop_frame(ok);
         total++; if (ok !== 1'b1) $display("FAIL cont_timeout frame=%0d got=%b exp=1", f, ok); else passed++;
         for (int w = 0; w < NW; w++) begin
            total++; if (got_q[w] !== exp_q[w]) $display("FAIL cont_word f=%0d w=%0d got=%h exp=%h", f, w, got_q[w], exp_q[w]); else passed++;
         end
         @(posedge clk); #1;
         total++; if (irq !== 1'b1) $display("FAIL cont_irq frame=%0d got=%b exp=1", f, irq); else passed++;
         total++; if (cam_enable !== 1'b1) $display("FAIL cont_rearm frame=%0d got=%b exp=1", f, cam_enable); else passed++;
      end
      repeat (2) @(posedge clk);
      wb_write(2'd1, 32'd0);
      total++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else passed++;
      wb_write(2'd0, 32'h8);
      wb_read(2'd1, d);
      total++; if (d !== 32'd0) $display("FAIL cont_abort_status got=%h exp=0", d); else passed++;
   endtask

   task automatic test_abort();
      logic [31:0] d;
      bit ok;
      for (int i = 0; i < NN; i++) ram[i] = 4'(i);
      build_expected();
      wb_write(2'd0, 32'h1);
      pulse_ready();
      wait_valid(ok);
      total++; if (ok !== 1'b1) $display("FAIL abort_hold_timeout got=%b exp=1", ok); else passed++;
      wb_write(2'd0, 32'h9);
      total++; if (cam_enable !== 1'b0 || cam_rd !== 1'b0) $display("FAIL abort_hold_pins got=%b%b exp=00", cam_enable, cam_rd); else passed++;
      wb_read(2'd1, d);
      total++; if (d !== 32'd0) $display("FAIL abort_hold_status got=%h exp=0", d); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd0) $display("FAIL abort_hold_count got=%h exp=0", d); else passed++;
      wb_write(2'd0, 32'h1);
      pulse_ready();
      pop_frame(ok);
      total++; if (ok !== 1'b1) $display("FAIL rearm_timeout got=%b exp=1", ok); else passed++;
      for (int w = 0; w < NW; w++) begin
         total++; if (got_q[w] !== exp_q[w]) $display("FAIL rearm_word w=%0d got=%h exp=%h", w, got_q[w], exp_q[w]); else passed++;
      end
      repeat (3) @(posedge clk);
      wb_write(2'd1, 32'd0);
   endtask

   task automatic test_ready_level();
      logic [31:0] d;
      bit ok;
      int rd0;
      for (int i = 0; i < NN; i++) ram[i] = 4'(NN - 1 - i);
      build_expected();
      @(negedge clk) cam_ready = 1'b1;
      repeat (3) @(posedge clk);
      rd0 = rd_pulses;
      wb_write(2'd0, 32'h1);
      repeat (10) @(posedge clk);
      #1;
      total++; if (cam_enable !== 1'b1) $display("FAIL level_enable got=%b exp=1", cam_enable); else passed++;
      total++; if (rd_pulses !== rd0) $display("FAIL level_no_fetch got=%0d exp=%0d", rd_pulses, rd0); else passed++;
      wb_read(2'd1, d);
      total++; if (d !== 32'h1) $display("FAIL level_status got=%h exp=1", d); else passed++;
      @(negedge clk) cam_ready = 1'b0;
      repeat (3) @(negedge clk);
      cam_ready = 1'b1;
      pop_frame(ok);
      cam_ready = 1'b0;
      total++; if (ok !== 1'b1) $display("FAIL level_timeout got=%b exp=1", ok); else passed++;
      for (int w = 0; w < NW; w++) begin
         total++; if (got_q[w] !== exp_q[w]) $display("FAIL level_word w=%0d got=%h exp=%h", w, got_q[w], exp_q[w]); else passed++;
      end
      repeat (3) @(posedge clk);
      wb_read(2'd1, d);
      total++; if (d !== 32'h4) $display("FAIL level_done got=%h exp=4", d); else passed++;
      wb_write(2'd1, 32'd0);
   endtask

   task automatic test_random_frames();
      logic [31:0] d, e;
      bit ok;
      int rd0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < NN; i++) ram[i] = 4'($urandom_range(0, 15));
         build_expected();
         rd0 = rd_pulses;
         wb_write(2'd0, 32'h1);
         pulse_ready();
         for (int w = 0; w < NW; w++) begin
            wait_valid(ok);
            total++; if (ok !== 1'b1) $display("FAIL rand_timeout f=%0d w=%0d got=%b exp=1", f, w, ok); else passed++;
            repeat ($urandom_range(0, 20)) @(posedge clk);
            wb_read(2'd2, d);
            e = exp_q.pop_front();
            total++; if (d !== e) $display("FAIL rand_word f=%0d w=%0d got=%h exp=%h", f, w, d, e); else passed++;
         end
         repeat (3) @(posedge clk);
         wb_read(2'd1, d);
         total++; if (d !== 32'h4) $display("FAIL rand_done f=%0d got=%h exp=4", f, d); else passed++;
         total++; if (rd_pulses - rd0 !== NN) $display("FAIL rand_strobes f=%0d got=%0d exp=%0d", f, rd_pulses - rd0, NN); else passed++;
         wb_write(2'd1, 32'd0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      wb_write(2'd0, 32'h5);
      pulse_ready();
      repeat (6) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      total++; if (cam_enable !== 1'b0 || cam_rd !== 1'b0 || irq !== 1'b0) $display("FAIL midreset_pins got=%b%b%b exp=000", cam_enable, cam_rd, irq); else passed++;
      total++; if (cam_addr !== '0) $display("FAIL midreset_addr got=%h exp=0", cam_addr); else passed++;
      @(negedge clk) reset = 1'b0;
      wb_read(2'd1, d);
      total++; if (d !== 32'd0) $display("FAIL midreset_status got=%h exp=0", d); else passed++;
      wb_read(2'd0, d);
      total++; if (d !== 32'd0) $display("FAIL midreset_ctrl got=%h exp=0", d); else passed++;
      wb_read(2'd3, d);
      total++; if (d !== 32'd0) $display("FAIL midreset_count got=%h exp=0", d); else passed++;
   endtask

   initial begin
      wb.wb_stb_i = 1'b0;
      wb.wb_cyc_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      wb.wb_adr_i = 32'd0;
      wb.wb_dat_i = 32'd0;
      for (int i = 0; i < NN; i++) ram[i] = 4'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1;
      test_reset();
      test_single_frame();
      test_underrun();
      test_continuous();
      test_abort();
      test_ready_level();
      test_random_frames();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
